// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: first-word-fall-through read port,
// occupancy count, almost-full watermark and sticky overflow/underflow flags.
module uart_rx_fifo #(
  parameter int WORD_WIDTH         = 8,
  parameter int DEPTH_LOG2         = 4,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] din,
  input  logic                  we,
  output logic                  full,
  output logic                  almost_full,
  output logic [WORD_WIDTH-1:0] dout,
  input  logic                  re,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // A margin covering the whole FIFO keeps the watermark permanently asserted.
  localparam bit            AF_ALWAYS = (ALMOST_FULL_MARGIN >= DEPTH);
  localparam logic [CW-1:0] AF_CNT    = AF_ALWAYS ? '0 : CW'(DEPTH - ALMOST_FULL_MARGIN);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr_acc;
  logic rd_acc;

  // Flags decode the registered count, so they only move at clock edges.
  assign full        = (count_q == CNT_FULL);
  assign empty       = (count_q == '0);
  assign almost_full = AF_ALWAYS || (count_q >= AF_CNT);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign dout        = empty ? '0 : mem_q[rd_ptr_q];

  assign wr_acc = we & ~full;
  assign rd_acc = re & ~empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (wr_acc && !rd_acc)      count_d = count_q + CNT_ONE;
    else if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;

    // Setting after the clear term lets a new error win over clr_err.
    if (we && full)  overflow_d  = 1'b1;
    if (re && empty) underflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; empty masks stale words.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at default parameters
// (8-bit words, 16 entries, almost_full at 14).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       we;
  logic       full;
  logic       almost_full;
  logic [7:0] dout;
  logic       re;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .we          (we),
    .full        (full),
    .almost_full (almost_full),
    .dout        (dout),
    .re          (re),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, let the edge happen, sample 1 ns later.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic c, input logic rs);
    we = w; din = d; re = r; clr_err = c; rst = rs;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; clr_err = 1'b0; rst = 1'b0; din = 8'h00;
  endtask

  task automatic test_reset;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_single;
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", empty); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL single_dout: got %h expected a5", dout); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty: got %b expected 1", empty); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_pop_count: got %0d expected 0", count); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL single_pop_dout: got %h expected 00", dout); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL single_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, almost_full, (i + 1 >= 14)); end
      checks++; if (full !== (i + 1 == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i + 1 == 16)); end
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", count); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL ovf_head: got %h expected 00", dout); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dout !== 8'(i)) begin errors++; $display("FAIL drain_dout[%0d]: got %h expected %h", i, dout, 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL drain_dout_final: got %h expected 00", dout); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_clr_err;
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %b expected 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL clr_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_wrap;
    // Pointers start at 0; 12 in / 12 out leaves them at 12.
    for (int i = 0; i < 12; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      checks++; if (dout !== 8'h20 + 8'(i)) begin errors++; $display("FAIL wrap_pre_dout[%0d]: got %h expected %h", i, dout, 8'h20 + 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    // 20 more words cross index 15 -> 0 with four in flight.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 4; i < 20; i++) begin
      checks++; if (dout !== 8'h40 + 8'(i - 4)) begin errors++; $display("FAIL wrap_dout[%0d]: got %h expected %h", i, dout, 8'h40 + 8'(i - 4)); end
      step(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0, 1'b0);
      checks++; if (count !== 5'd4) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected 4", i, count); end
    end
    for (int i = 16; i < 20; i++) begin
      checks++; if (dout !== 8'h40 + 8'(i)) begin errors++; $display("FAIL wrap_tail_dout[%0d]: got %h expected %h", i, dout, 8'h40 + 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  task automatic test_back_to_back;
    // Mid-occupancy: both accepted.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL b2b_mid_count: got %0d expected 5", count); end
    for (int i = 1; i < 6; i++) begin
      checks++; if (dout !== 8'h50 + 8'(i)) begin errors++; $display("FAIL b2b_mid_dout[%0d]: got %h expected %h", i, dout, 8'h50 + 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    // Full: read wins, write is dropped.
    for (int i = 0; i < 16; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL b2b_full_count: got %0d expected 15", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL b2b_full_overflow: got %b expected 1", overflow); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL b2b_full_flag: got %b expected 0", full); end
    for (int i = 1; i < 16; i++) begin
      checks++; if (dout !== 8'h60 + 8'(i)) begin errors++; $display("FAIL b2b_full_dout[%0d]: got %h expected %h", i, dout, 8'h60 + 8'(i)); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_full_drained: got %b expected 1", empty); end
    // Empty: write wins, read flagged as underflow.
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL b2b_empty_pre_dout: got %h expected 00", dout); end
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL b2b_empty_count: got %0d expected 1", count); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL b2b_empty_underflow: got %b expected 1", underflow); end
    checks++; if (dout !== 8'h77) begin errors++; $display("FAIL b2b_empty_dout: got %h expected 77", dout); end
  endtask

  task automatic test_clr_priority;
    // Entry state: count=1, both error flags set.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL prio_clr_overflow: got %b expected 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL prio_clr_underflow: got %b expected 0", underflow); end
    for (int i = 0; i < 15; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL prio_full: got %b expected 1", full); end
    step(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL prio_set_wins: got %b expected 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL prio_count: got %0d expected 16", count); end
  endtask

  task automatic test_rst_mid;
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL rst_pre_count: got %0d expected 7", count); end
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h expected 00", dout); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_hold_count: got %0d expected 0", count); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_underflow: got %b expected 0", underflow); end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; clr_err = 1'b0; din = 8'h00;
    test_reset;
    test_single;
    test_fill_overflow;
    test_clr_err;
    test_wrap;
    test_back_to_back;
    test_clr_priority;
    test_rst_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
